uart_sample_packer: RTL

- Upstream stage of the tone BRAM write controller.
- Consumes bytes from the UART receiver and hunts for a 2-byte frame header.
- Unpacks each 3 payload bytes into two 12-bit samples (a, b) and emits them as a single-cycle valid pulse with both samples.
- Supervises the frame with an inter-byte timeout, reports frame completion and errors, and re-arms for the next frame.

---
 rtl/uart_pack_pkg.sv | 15 +
 rtl/uart_sample_packer_byte_gap_timer.sv | 32 +++
 rtl/uart_sample_packer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/uart_pack_pkg.sv
// uart_pack_pkg: shared constants for the UART sample packer (state codes, default headers, phase width)
package uart_pack_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_HDR1W   = 3'd1;
    localparam logic [2:0] ST_PAYLOAD = 3'd2;
    localparam logic [2:0] ST_CHK     = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    localparam logic [7:0] HDR0_DEF = 8'hA5;
    localparam logic [7:0] HDR1_DEF = 8'h5A;

    localparam int PHASE_W = 2;

endpackage

// File: rtl/uart_sample_packer_byte_gap_timer.sv
// byte_gap_timer: counts idle cycles between received bytes and flags an over-long gap
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart the count (byte strobe, or packer idle)
//   enable     : count while the packer is inside a frame
//   expire     : one-cycle pulse when the gap reaches TIMEOUT_CYC cycles
module byte_gap_timer #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [W-1:0] cnt;

    // A strobe landing on the expiry cycle masks the expiry, so the byte wins.
    assign expire = enable && !clear && (cnt == W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear || expire)
            cnt <= '0;
        else if (enable)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/uart_sample_packer.sv
// uart_sample_packer: hunts a 2-byte header in the UART byte stream and unpacks 3 bytes into two 12-bit samples
//   clk, rst_n          : clock, asynchronous active-low reset
//   uart_rx_done/data   : one-cycle byte strobe and received byte
//   uart_rev_12_valid   : one-cycle pulse, uart_rev_12_a/b hold a new sample pair
//   pair_cnt            : pairs emitted in the current frame
//   frame_done/err      : one-cycle frame completion / abort pulses
//   busy                : high whenever not idle
// Define UART_PACK_CHECKSUM_EN to require a trailing mod-256 payload sum byte.
module uart_sample_packer
    import uart_pack_pkg::*;
#(
    parameter int          N_PAIRS     = 256,
    parameter logic [7:0]  HDR0        = HDR0_DEF,
    parameter logic [7:0]  HDR1        = HDR1_DEF,
    parameter int          TIMEOUT_CYC = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx_done,
    input  logic [7:0]  uart_rx_data,
    output logic        uart_rev_12_valid,
    output logic [11:0] uart_rev_12_a,
    output logic [11:0] uart_rev_12_b,
    output logic [15:0] pair_cnt,
    output logic        frame_done,
    output logic        frame_err,
    output logic        busy
);

    logic [2:0]         state;
    logic [PHASE_W-1:0] phase;
    logic [7:0]         a_hi;
    logic [3:0]         a_lo;
    logic [3:0]         b_hi;
    logic               expire;
    logic               timer_en;
    logic               last_pair;
`ifdef UART_PACK_CHECKSUM_EN
    logic [7:0]         sum;
`endif

    assign timer_en   = (state == ST_HDR1W) || (state == ST_PAYLOAD) || (state == ST_CHK);
    assign last_pair  = pair_cnt == 16'(N_PAIRS - 1);
    assign frame_done = state == ST_DONE;
    assign busy       = state != ST_IDLE;

    byte_gap_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (uart_rx_done || (state == ST_IDLE)),
        .enable (timer_en),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= ST_IDLE;
            phase             <= '0;
            a_hi              <= '0;
            a_lo              <= '0;
            b_hi              <= '0;
            uart_rev_12_valid <= 1'b0;
            uart_rev_12_a     <= '0;
            uart_rev_12_b     <= '0;
            pair_cnt          <= '0;
            frame_err         <= 1'b0;
`ifdef UART_PACK_CHECKSUM_EN
            sum               <= '0;
`endif
        end else begin
            uart_rev_12_valid <= 1'b0;
            frame_err         <= 1'b0;
            if (state == ST_DONE) begin
                state <= ST_IDLE;
            end else if (uart_rx_done) begin
                case (state)
                    ST_IDLE: begin
                        if (uart_rx_data == HDR0)
                            state <= ST_HDR1W;
                    end
                    ST_HDR1W: begin
                        if (uart_rx_data == HDR1) begin
                            state    <= ST_PAYLOAD;
                            pair_cnt <= '0;
                            phase    <= '0;
`ifdef UART_PACK_CHECKSUM_EN
                            sum      <= '0;
`endif
                        end else if (uart_rx_data != HDR0) begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_PAYLOAD: begin
`ifdef UART_PACK_CHECKSUM_EN
                        sum <= sum + uart_rx_data;
`endif
                        case (phase)
                            2'd0: begin
                                a_hi  <= uart_rx_data;
                                phase <= 2'd1;
                            end
                            2'd1: begin
                                a_lo  <= uart_rx_data[7:4];
                                b_hi  <= uart_rx_data[3:0];
                                phase <= 2'd2;
                            end
                            default: begin
                                uart_rev_12_a     <= {a_hi, a_lo};
                                uart_rev_12_b     <= {b_hi, uart_rx_data};
                                uart_rev_12_valid <= 1'b1;
                                pair_cnt          <= pair_cnt + 16'd1;
                                phase             <= 2'd0;
`ifdef UART_PACK_CHECKSUM_EN
                                if (last_pair)
                                    state <= ST_CHK;
`else
                                if (last_pair)
                                    state <= ST_DONE;
`endif
                            end
                        endcase
                    end
`ifdef UART_PACK_CHECKSUM_EN
                    ST_CHK: begin
                        state     <= (uart_rx_data == sum) ? ST_DONE : ST_IDLE;
                        frame_err <= uart_rx_data != sum;
                    end
`endif
                    default: state <= ST_IDLE;
                endcase
            end else if (expire) begin
                state     <= ST_IDLE;
                phase     <= '0;
                frame_err <= 1'b1;
            end
        end
    end

endmodule
